// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - host command sequencer between UART and 2D filter core
// Decodes h/w/f/o byte commands and streams filter output memory to the TX UART.
module uart_cmd_ctrl #(
  parameter int         ADDR_W = 16,
  parameter logic [7:0] CMD_H  = 8'h68,
  parameter logic [7:0] CMD_W  = 8'h77,
  parameter logic [7:0] CMD_F  = 8'h66,
  parameter logic [7:0] CMD_O  = 8'h6F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        height,
  output logic [7:0]        width,
  output logic              filt_start,
  input  logic              filt_busy,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, GET_H, GET_W, RD, WAIT, SEND} state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_addr;
  logic [15:0]       product;

  assign product = {8'd0, height} * {8'd0, width};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      height     <= '0;
      width      <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      last_addr  <= '0;
      filt_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      filt_start <= 1'b0;
      mem_ren    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_H: begin
                state <= GET_H;
                busy  <= 1'b1;
              end
              CMD_W: begin
                state <= GET_W;
                busy  <= 1'b1;
              end
              CMD_F: begin
                if (!filt_busy) filt_start <= 1'b1;
              end
              CMD_O: begin
                // Last address is frozen here so mid-dump h/w writes cannot alter the length
                if (!filt_busy) begin
                  mem_raddr <= '0;
                  last_addr <= ADDR_W'(product - 16'd1);
                  if (product != 16'd0) begin
                    state   <= RD;
                    busy    <= 1'b1;
                    mem_ren <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        GET_H: begin
          if (rx_valid) begin
            height <= rx_data;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        GET_W: begin
          if (rx_valid) begin
            width <= rx_data;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RD: begin
          state <= WAIT;
        end
        WAIT: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (mem_raddr == last_addr) begin
              mem_raddr <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              mem_raddr <= mem_raddr + ADDR_W'(1);
              mem_ren   <= 1'b1;
              state     <= RD;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              tx_ready = 1'b0;
  logic              filt_busy = 1'b0;
  logic [7:0]        mem_rdata = 8'd0;
  logic [7:0]        tx_data, height, width;
  logic              tx_valid, mem_ren, filt_start, busy;
  logic [ADDR_W-1:0] mem_raddr;

  logic [7:0] mem [0:65535];
  logic [7:0] log_q [$];
  logic [7:0] exp_bytes [0:5] = '{8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  int vectors = 0, errors = 0;
  int ren_cnt = 0, start_cnt = 0, cyc = 0, last_hs = -1, min_gap = 1000;

  uart_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .height(height), .width(width), .filt_start(filt_start),
    .filt_busy(filt_busy), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_ren) begin
      mem_rdata <= mem[mem_raddr];
      ren_cnt = ren_cnt + 1;
    end
    if (filt_start) start_cnt = start_cnt + 1;
    if (tx_valid && tx_ready && !rst) begin
      log_q.push_back(tx_data);
      if (last_hs >= 0 && (cyc - last_hs) < min_gap) min_gap = cyc - last_hs;
      last_hs = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic clear_mon();
    log_q.delete();
    ren_cnt = 0;
    start_cnt = 0;
    last_hs = -1;
    min_gap = 1000;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++; errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tx_valid, mem_ren, filt_start, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: valid/ren/start/busy=%b required 0000", {tx_valid, mem_ren, filt_start, busy});
    end
    vectors++;
    if ({height, width, tx_data} !== 24'd0 || mem_raddr !== '0) begin
      errors++;
      $display("FAIL reset_regs: h=%0d w=%0d tx=%0d addr=%0d required all 0", height, width, tx_data, mem_raddr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dump();
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h68); send_byte(8'd2);
    send_byte(8'h77); send_byte(8'd3);
    vectors++;
    if (height !== 8'd2 || width !== 8'd3) begin
      errors++;
      $display("FAIL set_hw: h=%0d w=%0d required 2 3", height, width);
    end
    send_byte(8'h6F);
    wait_idle("dump_idle");
    vectors++;
    if (log_q.size() != 6) begin
      errors++;
      $display("FAIL dump_count: %0d bytes required 6", log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (log_q[i] !== exp_bytes[i]) begin
          errors++;
          $display("FAIL dump_byte%0d: got %0d required %0d", i, log_q[i], exp_bytes[i]);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || mem_raddr !== '0) begin
      errors++;
      $display("FAIL dump_end: busy=%b addr=%0d required 0 0", busy, mem_raddr);
    end
    vectors++;
    if (min_gap != 3) begin
      errors++;
      $display("FAIL dump_spacing: min gap %0d required 3", min_gap);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    logic [7:0] d;
    logic stable = 1'b1;
    clear_mon();
    tx_ready = 1'b0;
    send_byte(8'h6F);
    while (tx_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    d = tx_data;
    vectors++;
    if (tx_valid !== 1'b1 || d !== 8'd3) begin
      errors++;
      $display("FAIL stall_first: valid=%b data=%0d required 1 3", tx_valid, d);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== d) stable = 1'b0;
    end
    vectors++;
    if (stable !== 1'b1 || log_q.size() != 0) begin
      errors++;
      $display("FAIL stall_hold: stable=%b sent=%0d required 1 0", stable, log_q.size());
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    vectors++;
    if (log_q.size() != 1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: sent=%0d valid=%b required 1 0", log_q.size(), tx_valid);
    end
    tx_ready = 1'b1;
    wait_idle("stall_idle");
    vectors++;
    if (log_q.size() != 6 || log_q[log_q.size()-1] !== 8'd5) begin
      errors++;
      $display("FAIL stall_total: sent=%0d required 6 ending in 5", log_q.size());
    end
  endtask

  task automatic test_zero_and_unknown();
    send_byte(8'h68); send_byte(8'd0);
    send_byte(8'h77); send_byte(8'd7);
    clear_mon();
    send_byte(8'h6F);
    repeat (10) @(negedge clk);
    vectors++;
    if (ren_cnt != 0 || log_q.size() != 0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_dump: ren=%0d sent=%0d busy=%b valid=%b required 0 0 0 0",
               ren_cnt, log_q.size(), busy, tx_valid);
    end
    send_byte(8'h78);
    send_byte(8'd5);
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || height !== 8'd0 || width !== 8'd7 || ren_cnt != 0) begin
      errors++;
      $display("FAIL unknown_byte: busy=%b h=%0d w=%0d ren=%0d required 0 0 7 0", busy, height, width, ren_cnt);
    end
  endtask

  task automatic test_filter();
    send_byte(8'h68); send_byte(8'd2);
    send_byte(8'h77); send_byte(8'd3);
    clear_mon();
    filt_busy = 1'b0;
    send_byte(8'h66);
    repeat (4) @(negedge clk);
    vectors++;
    if (start_cnt != 1 || filt_start !== 1'b0) begin
      errors++;
      $display("FAIL filt_pulse: high cycles=%0d now=%b required 1 0", start_cnt, filt_start);
    end
    clear_mon();
    filt_busy = 1'b1;
    send_byte(8'h66);
    send_byte(8'h6F);
    repeat (10) @(negedge clk);
    vectors++;
    if (start_cnt != 0 || ren_cnt != 0 || log_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL filt_busy_block: start=%0d ren=%0d sent=%0d busy=%b required 0 0 0 0",
               start_cnt, ren_cnt, log_q.size(), busy);
    end
    filt_busy = 1'b0;
  endtask

  task automatic test_inject();
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h6F);
    send_byte(8'h68);
    send_byte(8'd9);
    wait_idle("inject_idle");
    vectors++;
    if (height !== 8'd2 || log_q.size() != 6) begin
      errors++;
      $display("FAIL inject_drop: h=%0d sent=%0d required 2 6", height, log_q.size());
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL inject_state: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h6F);
    while (log_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx_valid !== 1'b1 || log_q.size() != 2) begin
      errors++;
      $display("FAIL mid_setup: valid=%b sent=%0d required 1 2", tx_valid, log_q.size());
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || height !== 8'd0 || width !== 8'd0 || mem_raddr !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b h=%0d w=%0d addr=%0d required 0 0 0 0 0",
               tx_valid, busy, height, width, mem_raddr);
    end
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    send_byte(8'h68); send_byte(8'd1);
    send_byte(8'h77); send_byte(8'd1);
    clear_mon();
    send_byte(8'h6F);
    wait_idle("mid_idle");
    vectors++;
    if (log_q.size() != 1 || log_q[0] !== 8'd3) begin
      errors++;
      $display("FAIL mid_fresh: sent=%0d first=%0d required 1 3", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : 8'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) mem[i] = 8'(i);
    mem[0] = 8'd3;
    test_reset();
    test_dump();
    test_stall();
    test_zero_and_unknown();
    test_filter();
    test_inject();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
